adder_cla_reg: RTL and testbench

//   8-bit binary adder with carry-in and carry-out: {oData_C,oData} = iData_a + iData_b + iC.
//   Sum is built from 4-bit carry-lookahead groups (group P/G, rippled group carry).

---
 rtl/adder_cla_reg.sv | 121 ++++++++++++
 tb/tb_adder_cla_reg.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/adder_cla_reg.sv
// ---------------------------------------------------------------------------
// adder_cla_reg
//   Registered WIDTH-bit adder with carry-in, carry-out and signed overflow.
//   The sum is built from 4-bit carry-lookahead groups. Each group computes
//   its internal carries in lookahead form. The group carry-out is formed from
//   the group propagate/generate pair and ripples into the next group.
//   The result is captured in a register, so it appears one clock after the
//   operands. A new operand set can be accepted on every cycle.
//
// Ports
//   iClk     in   1      clock, rising edge
//   iRst_n   in   1      synchronous reset, active low
//   iData_a  in   WIDTH  operand A (unsigned; two's complement for oOvf)
//   iData_b  in   WIDTH  operand B
//   iC       in   1      carry-in
//   iValid   in   1      operands valid this cycle
//   oData    out  WIDTH  registered sum bits
//   oData_C  out  1      registered carry-out
//   oOvf     out  1      registered signed overflow
//   oValid   out  1      high for one cycle when a new result is presented
// ---------------------------------------------------------------------------
module adder_cla_reg #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  input  logic             iValid,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oOvf,
  output logic             oValid
);

  localparam int NumGroups = WIDTH / 4;

  logic [WIDTH-1:0] bitP;
  logic [WIDTH-1:0] bitG;

  logic [WIDTH-1:0] sumData_d;
  logic             carryOut_d;
  logic             ovf_d;

  logic [3:0]       grpP;
  logic [3:0]       grpG;
  logic [4:0]       grpC;
  logic             grpPg;
  logic             grpGg;
  logic             groupCarry;
  logic             carryIntoMsb;

  logic [WIDTH-1:0] sumData_q;
  logic             carryOut_q;
  logic             ovf_q;
  logic             valid_q;

  // Per-bit propagate and generate terms.
  assign bitP = iData_a ^ iData_b;
  assign bitG = iData_a & iData_b;

  // Walk the 4-bit groups from LSB to MSB. Within a group, every carry is
  // expanded in lookahead form from the group carry-in. Only the group
  // carry-out ripples to the next group, and it comes from the group PG/GG pair.
  // The carry into the MSB is the top internal carry of the last group.
  // Overflow compares that carry with the final carry-out.
  always_comb begin
    sumData_d    = '0;
    grpP         = '0;
    grpG         = '0;
    grpC         = '0;
    grpPg        = 1'b0;
    grpGg        = 1'b0;
    groupCarry   = iC;
    carryIntoMsb = 1'b0;
    for (int k = 0; k < NumGroups; k++) begin
      grpP    = bitP[4*k +: 4];
      grpG    = bitG[4*k +: 4];
      grpC[0] = groupCarry;
      grpC[1] = grpG[0] | (grpP[0] & groupCarry);
      grpC[2] = grpG[1] | (grpP[1] & grpG[0]) | (grpP[1] & grpP[0] & groupCarry);
      grpC[3] = grpG[2] | (grpP[2] & grpG[1]) | (grpP[2] & grpP[1] & grpG[0])
              | (grpP[2] & grpP[1] & grpP[0] & groupCarry);
      grpPg   = &grpP;
      grpGg   = grpG[3] | (grpP[3] & grpG[2]) | (grpP[3] & grpP[2] & grpG[1])
              | (grpP[3] & grpP[2] & grpP[1] & grpG[0]);
      grpC[4] = grpGg | (grpPg & groupCarry);
      sumData_d[4*k +: 4] = grpP ^ grpC[3:0];
      carryIntoMsb = grpC[3];
      groupCarry   = grpC[4];
    end
    carryOut_d = groupCarry;
    ovf_d      = carryIntoMsb ^ groupCarry;
  end

  // Result register. Reset takes priority over iValid. When no valid
  // operands arrive, the previous result is held and oValid drops. oValid
  // therefore marks only freshly computed results.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sumData_q  <= '0;
      carryOut_q <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (iValid) begin
        sumData_q  <= sumData_d;
        carryOut_q <= carryOut_d;
        ovf_q      <= ovf_d;
      end
      valid_q <= iValid;
    end
  end

  assign oData   = sumData_q;
  assign oData_C = carryOut_q;
  assign oOvf    = ovf_q;
  assign oValid  = valid_q;

endmodule

// File: tb/tb_adder_cla_reg.sv
// ---------------------------------------------------------------------------
// tb_adder_cla_reg
//   Self-checking bench for adder_cla_reg (WIDTH = 8). A table of directed
//   vectors is applied back to back. Hand-written sequences cover reset,
//   hold on iValid=0, and reset in the middle of a stream. A random sweep is
//   then checked against a behavioural a+b+c model.
// ---------------------------------------------------------------------------
module tb_adder_cla_reg;

  logic       clk;
  logic       rstN;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       carryIn;
  logic       validIn;
  logic [7:0] sumOut;
  logic       carryOut;
  logic       ovfOut;
  logic       validOut;

  int checkCount;
  int passCount;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] expData;
    logic       expC;
    logic       expOvf;
  } vector_t;

  vector_t vectors[8];

  adder_cla_reg #(.WIDTH(8)) dut (
    .iClk    (clk),
    .iRst_n  (rstN),
    .iData_a (dataA),
    .iData_b (dataB),
    .iC      (carryIn),
    .iValid  (validIn),
    .oData   (sumOut),
    .oData_C (carryOut),
    .oOvf    (ovfOut),
    .oValid  (validOut)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge. The task returns 1 ns after the
  // following rising edge, so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic rst, input logic [7:0] a,
                               input logic [7:0] b, input logic c,
                               input logic v);
    @(negedge clk);
    rstN    = rst;
    dataA   = a;
    dataB   = b;
    carryIn = c;
    validIn = v;
    @(posedge clk);
    #1;
  endtask

  // Compares one output against its expected value and counts the check.
  task automatic checkOutput(input string name, input logic [8:0] actual,
                             input logic [8:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passCount++;
  endtask

  // Checks all four outputs against one expected result.
  task automatic checkAll(input string tag, input logic [7:0] d, input logic c,
                          input logic o, input logic v);
    checkOutput({tag, ".data"},  {1'b0, sumOut},   {1'b0, d});
    checkOutput({tag, ".carry"}, {8'd0, carryOut}, {8'd0, c});
    checkOutput({tag, ".ovf"},   {8'd0, ovfOut},   {8'd0, o});
    checkOutput({tag, ".valid"}, {8'd0, validOut}, {8'd0, v});
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] full;
    logic       expOvf;

    checkCount = 0;
    passCount  = 0;
    rstN    = 1'b0;
    dataA   = 8'h00;
    dataB   = 8'h00;
    carryIn = 1'b0;
    validIn = 1'b0;

    vectors[0] = '{8'b00000010, 8'b00000001, 1'b0, 8'b00000011, 1'b0, 1'b0};
    vectors[1] = '{8'b00100010, 8'b00100001, 1'b1, 8'b01000100, 1'b0, 1'b0};
    vectors[2] = '{8'b10000010, 8'b10000000, 1'b1, 8'b00000011, 1'b1, 1'b1};
    vectors[3] = '{8'hFF,       8'h00,       1'b1, 8'h00,       1'b1, 1'b0};
    vectors[4] = '{8'hFF,       8'hFF,       1'b1, 8'hFF,       1'b1, 1'b0};
    vectors[5] = '{8'h80,       8'h80,       1'b0, 8'h00,       1'b1, 1'b1};
    vectors[6] = '{8'h0F,       8'h01,       1'b0, 8'h10,       1'b0, 1'b0};
    vectors[7] = '{8'h7F,       8'h01,       1'b0, 8'h80,       1'b0, 1'b1};

    // Hold reset while iValid is high; reset must win.
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
    checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Directed table, one vector per cycle with no gaps.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vectors[i].a, vectors[i].b, vectors[i].c, 1'b1);
      checkAll($sformatf("vec%0d", i), vectors[i].expData, vectors[i].expC,
               vectors[i].expOvf, 1'b1);
    end

    // With iValid low, the previous result (7F+01) is held and oValid drops.
    // The operands change to prove they are ignored.
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
    checkAll("hold1", 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0);
    checkAll("hold2", 8'h80, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a stream discards the result.
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
    checkAll("preRst", 8'h30, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h44, 8'h44, 1'b1, 1'b1);
    checkAll("midRst", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 8'h44, 1'b1, 1'b1);
    checkAll("postRst", 8'h89, 1'b0, 1'b1, 1'b1);

    // Random sweep against the behavioural model.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      full   = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      expOvf = (ra[7] == rb[7]) && (full[7] != ra[7]);
      applyStimulus(1'b1, ra, rb, rc, 1'b1);
      checkAll($sformatf("rnd%0d", i), full[7:0], full[8], expOvf, 1'b1);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
